// File: rtl/seq_pattern_gen_if.sv
// Bundle for the serial pattern generator: frame request going in, serial
// stream and frame status coming out.
//
// Handshake: start is a level request with no separate ready. It is taken
// only while busy=0 (IDLE). A start with a legal len is accepted at that
// rising edge, and busy rises in the next cycle. A start with an illegal
// len gets a one-cycle err in the next cycle and no frame. pat and len are
// only sampled on the acceptance edge.
interface seq_pattern_gen_if #(
  parameter int PLEN = 16
);
  logic            start;
  logic [PLEN-1:0] pat;
  logic [4:0]      len;
  logic            w;
  logic            w_valid;
  logic            z_exp;
  logic            busy;
  logic            done;
  logic            err;

  // Requester side: drives the frame request, observes stream and status.
  modport master (
    output start, pat, len,
    input  w, w_valid, z_exp, busy, done, err
  );

  // Generator side.
  modport slave (
    input  start, pat, len,
    output w, w_valid, z_exp, busy, done, err
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator for exercising a run-of-four detector. Shifts a
// captured pattern out LSB first on w and produces z_exp, the output a Moore
// run-of-four detector clocked alongside would give for that stream.
module seq_pattern_gen #(
  parameter int PLEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_pattern_gen_if.slave      bus,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_DONE  = 3'b100
  } state_t;

  localparam logic [31:0] PLEN_U = PLEN;

  state_t          state_q;
  state_t          state_d;

  logic [PLEN-1:0] sreg_q;   // remaining pattern bits, next bit in [0]
  logic [4:0]      cnt_q;    // bits still to send, including the current one
  logic [2:0]      run_q;    // length of the current run, saturating at 4
  logic            prev_q;   // last bit sent in this frame
  logic            err_q;

  logic            len_legal;
  logic            accept;
  logic            reject;
  logic            shifting;
  logic            w_cur;
  logic            w_valid_cur;
  logic            busy_cur;
  logic            done_cur;

  // Length 0 and lengths beyond the pattern register are rejected.
  always_comb begin
    len_legal = (bus.len != 5'd0) && ({27'd0, bus.len} <= PLEN_U);
  end

  // State register; reset forces IDLE, abandoning any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    reject      = 1'b0;
    shifting    = 1'b0;
    w_cur       = 1'b0;
    w_valid_cur = 1'b0;
    busy_cur    = 1'b0;
    done_cur    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (len_legal) begin
            accept  = 1'b1;
            state_d = S_SHIFT;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        shifting    = 1'b1;
        w_cur       = sreg_q[0];
        w_valid_cur = 1'b1;
        busy_cur    = 1'b1;
        // cnt_q==1 means the bit on w now is the last one of the frame.
        if (cnt_q == 5'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_cur = 1'b1;
        done_cur = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        // Any non-one-hot value falls back to IDLE.
        state_d = S_IDLE;
      end
    endcase
  end

  // Pattern shift register and bit down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= 5'd0;
    end else if (accept) begin
      sreg_q <= bus.pat;
      cnt_q  <= bus.len;
    end else if (shifting) begin
      sreg_q <= {1'b0, sreg_q[PLEN-1:1]};
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  // Run tracking: run_q==0 marks "no bit sent yet in this frame", so the
  // first bit always starts a run of one and nothing carries between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q  <= 3'd0;
      prev_q <= 1'b0;
    end else if (accept) begin
      run_q  <= 3'd0;
      prev_q <= 1'b0;
    end else if (shifting) begin
      prev_q <= w_cur;
      if (run_q == 3'd0) begin
        run_q <= 3'd1;
      end else if (w_cur == prev_q) begin
        run_q <= (run_q == 3'd4) ? 3'd4 : run_q + 3'd1;
      end else begin
        run_q <= 3'd1;
      end
    end else if (state_q == S_DONE) begin
      // Leaving DONE: drop the run so z_exp is low in IDLE.
      run_q  <= 3'd0;
      prev_q <= 1'b0;
    end
  end

  // Rejected start is flagged for exactly the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
    end
  end

  // run_q is a register updated on the edge that consumed bit k, so this
  // flag shows in cycle k+1 like a Moore detector output, through DONE.
  always_comb begin
    bus.z_exp = (run_q == 3'd4);
  end

  // Stream and status outputs.
  always_comb begin
    bus.w       = w_cur;
    bus.w_valid = w_valid_cur;
    bus.busy    = busy_cur;
    bus.done    = done_cur;
    bus.err     = err_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed vector table, hand sequences for the
// multi-cycle corners, and random frames against a bit-level reference.
module tb_seq_pattern_gen;

  localparam int PLEN = 16;

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  len;
    logic [15:0] exp_w;   // bit k-1 is w in frame cycle k
    logic [31:0] exp_z;   // bit c is z_exp in frame cycle c
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;
  int         total;
  int         bad;
  vec_t       tbl[8];
  logic [4:0] exp_q[$];   // {w_valid, w, z_exp, busy, done} per cycle

  seq_pattern_gen_if #(.PLEN(PLEN)) bus ();

  seq_pattern_gen #(.PLEN(PLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // One sampled cycle against explicit expectations.
  task automatic chk_cycle(input string nm, input logic ew, input logic ewv,
                           input logic ez, input logic eb, input logic ed, input logic ee);
    chk({nm, ".w"},       32'(bus.w),       32'(ew));
    chk({nm, ".w_valid"}, 32'(bus.w_valid), 32'(ewv));
    chk({nm, ".z_exp"},   32'(bus.z_exp),   32'(ez));
    chk({nm, ".busy"},    32'(bus.busy),    32'(eb));
    chk({nm, ".done"},    32'(bus.done),    32'(ed));
    chk({nm, ".err"},     32'(bus.err),     32'(ee));
  endtask

  // Reference: a run of four ends at bit k when the last four bits agree.
  function automatic logic run4_at(input logic [15:0] p, input int k);
    if (k < 4) return 1'b0;
    return (p[k-1] == p[k-2]) && (p[k-2] == p[k-3]) && (p[k-3] == p[k-4]);
  endfunction

  // Push the expected cycles 1..len+2 of a frame onto the scoreboard.
  task automatic model_frame(input logic [15:0] p, input int n);
    logic [4:0] rec;
    for (int c = 1; c <= n + 2; c++) begin
      rec = 5'b0;
      if (c <= n) begin
        rec[4] = 1'b1;
        rec[3] = p[c-1];
      end
      if (c >= 2 && c <= n + 1) rec[2] = run4_at(p, c - 1);
      if (c <= n + 1) rec[1] = 1'b1;
      if (c == n + 1) rec[0] = 1'b1;
      exp_q.push_back(rec);
    end
  endtask

  // Drive a start for one cycle; returns at mid-cycle before the accepting edge.
  task automatic drive_start(input logic [15:0] p, input logic [4:0] n);
    @(negedge clk);
    bus.pat   = p;
    bus.len   = n;
    bus.start = 1'b1;
  endtask

  // Table-driven frame, checked cycle by cycle against the table constants.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    n = int'(v.len);
    drive_start(v.pat, v.len);
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      chk_cycle($sformatf("vec%0d.c%0d", idx, c),
                (c <= n) ? v.exp_w[c-1] : 1'b0, c <= n, v.exp_z[c],
                c <= n + 1, c == n + 1, 1'b0);
      if (c == 1) bus.start = 1'b0;
    end
  endtask

  // Random frame with junk on the inputs after acceptance.
  task automatic run_random(input int idx);
    logic [15:0] p;
    logic [4:0]  n;
    logic [4:0]  exp;
    logic [4:0]  act;
    p = 16'($urandom);
    n = 5'($urandom_range(1, 16));
    model_frame(p, int'(n));
    drive_start(p, n);
    for (int c = 1; c <= int'(n) + 2; c++) begin
      @(negedge clk);
      act = {bus.w_valid, bus.w, bus.z_exp, bus.busy, bus.done};
      if (exp_q.size() == 0) begin
        chk($sformatf("rnd%0d.c%0d.queue", idx, c), 32'(act), 32'h1F);
      end else begin
        exp = exp_q.pop_front();
        chk($sformatf("rnd%0d.c%0d", idx, c), 32'(act), 32'(exp));
      end
      chk($sformatf("rnd%0d.c%0d.err", idx, c), 32'(bus.err), 32'd0);
      bus.pat   = 16'($urandom);
      bus.len   = 5'($urandom_range(0, 31));
      bus.start = (c <= int'(n) + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  // Illegal length: err for exactly one cycle, no frame.
  task automatic run_reject(input logic [4:0] n, input string nm);
    drive_start(16'hFFFF, n);
    @(negedge clk);
    chk_cycle({nm, ".c1"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b0;
    @(negedge clk);
    chk_cycle({nm, ".c2"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int    done_cnt;
    logic [3:0] w2;
    total     = 0;
    bad       = 0;
    bus.start = 1'b0;
    bus.pat   = '0;
    bus.len   = 5'd0;

    tbl[0] = '{16'h000F, 5'd8,  16'h000F, 32'h0000_0220};
    tbl[1] = '{16'hAAAA, 5'd16, 16'hAAAA, 32'h0000_0000};
    tbl[2] = '{16'h00FF, 5'd6,  16'h00FF, 32'h0000_00E0};
    tbl[3] = '{16'hFFFF, 5'd16, 16'hFFFF, 32'h0003_FFE0};
    tbl[4] = '{16'h8000, 5'd16, 16'h8000, 32'h0001_FFE0};
    tbl[5] = '{16'h7777, 5'd16, 16'h7777, 32'h0000_0000};
    tbl[6] = '{16'h0000, 5'd4,  16'h0000, 32'h0000_0020};
    tbl[7] = '{16'h0001, 5'd1,  16'h0001, 32'h0000_0000};

    // Reset: outputs low and FSM in IDLE before any clock edge.
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.state", 32'(state_dbg), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    run_reject(5'd0,  "len0");
    run_reject(5'd17, "len17");
    run_reject(5'd31, "len31");

    // Start re-pulsed and pat changed mid-frame: both ignored.
    done_cnt = 0;
    drive_start(16'h00FF, 5'd6);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk_cycle($sformatf("ignore.c%0d", c), c <= 6, c <= 6,
                (c >= 5 && c <= 7), c <= 7, c == 7, 1'b0);
      if (bus.done) done_cnt++;
      if (c == 1) bus.start = 1'b0;
      if (c == 2) bus.pat = 16'h0000;
      if (c == 3) bus.start = 1'b1;
      if (c == 4) bus.start = 1'b0;
    end
    chk("ignore.done_count", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of cycle 3 of a len=8 frame.
    drive_start(16'hFFFF, 5'd8);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_cycle("midrst.now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.state", 32'(state_dbg), 32'h1);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("midrst.no_done", 32'(done_cnt), 32'd0);
    rst       = 1'b1;
    bus.pat   = 16'h0001;
    bus.len   = 5'd1;
    bus.start = 1'b1;
    @(negedge clk);
    chk_cycle("postrst.c1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    chk_cycle("postrst.c2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_cycle("postrst.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second start held from the DONE cycle of the first.
    drive_start(16'hFFFF, 5'd4);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    chk_cycle("b2b.done1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.pat   = 16'h0007;
    bus.len   = 5'd4;
    bus.start = 1'b1;
    @(negedge clk);
    chk_cycle("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    w2 = 4'b0111;
    for (int d = 1; d <= 5; d++) begin
      @(negedge clk);
      chk_cycle($sformatf("b2b.f2c%0d", d), (d <= 4) ? w2[d-1] : 1'b0,
                d <= 4, 1'b0, 1'b1, d == 5, 1'b0);
      if (d == 1) bus.start = 1'b0;
    end
    @(negedge clk);

    // Random frames against the reference model.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        run_reject(($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31)),
                   $sformatf("rndrej%0d", i));
      end
      run_random(i);
    end
    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 The block SHALL have parameter PLEN, default 16, giving the maximum pattern length in bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; one clock; polarity and synchronicity are fixed.
REQ-004 start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-005 pat  input  PLEN  pattern to send, LSB first; captured on an accepted start.
REQ-006 len  input  5  number of bits to send, legal range 1..PLEN; captured on an accepted start.
REQ-007 w  output  1  serial bit stream that feeds the run-of-four detector's w input.
REQ-008 w_valid  output  1  high in every cycle where w carries a frame bit.
REQ-009 z_exp  output  1  expected detector z: a registered run-of-four flag.
REQ-010 busy  output  1  high from start acceptance until the DONE cycle, inclusive.
REQ-011 done  output  1  one-cycle pulse that ends a frame.
REQ-012 err  output  1  one-cycle pulse that flags a rejected start.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, and SHALL use one-hot state encoding.
REQ-014 The FSM SHALL go IDLE->SHIFT when start=1 and 1<=len<=PLEN at a rising edge.
- At that edge, pat goes into a shift register, len goes into a down-counter, and the run counter clears.
REQ-015 When start=1 and len=0 or len>PLEN in IDLE, the block SHALL stay in IDLE and pulse err high for the next cycle only.
REQ-016 In SHIFT cycle k (k=1..len, counted from the acceptance edge), w SHALL equal captured pat[k-1] and w_valid SHALL be 1.
REQ-017 After the cycle where k=len, the FSM SHALL go SHIFT->DONE.
- DONE lasts exactly one cycle: done=1, busy=1, w_valid=0, w=0.
- DONE is followed by IDLE.
REQ-018 In IDLE: w=0, w_valid=0, busy=0, done=0, z_exp=0.
REQ-019 The block SHALL ignore start in SHIFT and DONE, and SHALL ignore changes on pat or len after the acceptance edge.
REQ-020 Run counter: 3 bits, saturating at 4.
- First bit of a frame: run=1.
- Each later bit: run+1 if the bit equals the previous bit, otherwise run=1.
REQ-021 z_exp SHALL be registered: in cycle k+1, z_exp=1 if run>=4 after bit k, otherwise 0.
- This holds for SHIFT and DONE cycles alike, so z_exp matches a Moore detector driven by w on the same clock.
REQ-022 A run SHALL NOT carry across frames; each accepted start clears run history.
REQ-023 The earliest new start SHALL be accepted in the first IDLE cycle after DONE.
- Minimum frame period is len+2 cycles.

Reset
REQ-024 When rst=0, all state SHALL clear immediately and asynchronously, without waiting for clk.
- FSM goes to IDLE; shift register, down-counter and run counter go to 0.
- Outputs w, w_valid, z_exp, busy, done and err go to 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no done pulse; the first rising edge after rst returns to 1 SHALL accept start normally.

Verification
REQ-026 pat=16'h000F, len=8, start pulsed ->
- w=1,1,1,1,0,0,0,0 in cycles 1..8, with w_valid=1 throughout;
- z_exp=1 in cycles 5 and 9 only;
- done=1 in cycle 9; busy=0 from cycle 10.
REQ-027 pat=16'hAAAA, len=16 ->
- w alternates 0,1,... in cycles 1..16;
- z_exp stays 0 throughout;
- done=1 in cycle 17.
REQ-028 start with len=0, then start with len=17 -> err=1 for one cycle after each; busy, w_valid and done stay 0.
REQ-029 pat=16'h00FF, len=6, start re-pulsed in cycle 3, pat changed to 0 in cycle 2 ->
- w=1,1,1,1,1,1, unaffected by the pat change;
- z_exp=1 in cycles 5, 6 and 7;
- exactly one done pulse, in cycle 7.
REQ-030 rst driven to 0 in the middle of cycle 3 of a len=8 frame ->
- all outputs go to 0 before the next edge;
- no done pulse;
- after release, start with pat=16'h0001, len=1 gives w=1 in cycle 1 and done in cycle 2.
REQ-031 Back-to-back frames: second start held high continuously from the DONE cycle -> accepted at the first IDLE edge, and z_exp for the second frame is unaffected by the first frame's final run.
